instr_stream_writer: RTL

//   Encodes abstract MIPS operation requests (op + register/immediate fields) into 32-bit

---
 rtl/instr_stream_writer_pkg.sv | 52 +++++
 rtl/instr_stream_writer_if.sv | 25 ++
 rtl/instr_stream_writer_encode.sv | 34 +++
 rtl/instr_stream_writer.sv | 111 +++++++++++
 4 files changed

// File: rtl/instr_stream_writer_pkg.sv
// MIPS op codes, opcode/funct values and field packers shared with the control decoder.
// Pure definitions: no logic, no timing.
package instr_stream_writer_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_XOR = 4'd2,
    OP_JR  = 4'd3,
    OP_ORI = 4'd4,
    OP_LUI = 4'd5,
    OP_LW  = 4'd6,
    OP_SW  = 4'd7,
    OP_BEQ = 4'd8,
    OP_J   = 4'd9,
    OP_JAL = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam int unsigned WORD_CNT_W = 11;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm16);
    return {opc, rs, rt, imm16};
  endfunction

endpackage

// File: rtl/instr_stream_writer_if.sv
// Request stream (in_*) and instruction-memory write port (im_*) bundle.
// master = test controller / memory side, slave = the writer.
interface instr_stream_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [25:0] in_imm;
  logic        im_we;
  logic        im_ready;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, im_ready,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, im_ready,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_stream_writer_encode.sv
// Combinational op + fields -> 32-bit MIPS word; ops 11-15 flag illegal with a zero word.
// Zero latency, no backpressure.
module instr_stream_writer_encode
  import instr_stream_writer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  word = enc_r(rs, rt, rd, FN_ADD);
      OP_SUB:  word = enc_r(rs, rt, rd, FN_SUB);
      OP_XOR:  word = enc_r(rs, rt, rd, FN_XOR);
      OP_JR:   word = {OPC_RTYPE, rs, 15'h0000, FN_JR};
      OP_ORI:  word = enc_i(OPC_ORI, rs, rt, imm[15:0]);
      OP_LUI:  word = enc_i(OPC_LUI, 5'h00, rt, imm[15:0]);
      OP_LW:   word = enc_i(OPC_LW, rs, rt, imm[15:0]);
      OP_SW:   word = enc_i(OPC_SW, rs, rt, imm[15:0]);
      OP_BEQ:  word = enc_i(OPC_BEQ, rs, rt, imm[15:0]);
      OP_J:    word = {OPC_J, imm};
      OP_JAL:  word = {OPC_JAL, imm};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_writer.sv
// Encodes op requests and writes them sequentially into IM from BASE_ADDR upward.
// One-cycle accept->im_we latency; output register stalls on !im_ready, which drops in_ready.
module instr_stream_writer
  import instr_stream_writer_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  finish,
  instr_stream_writer_if.slave  bus,
  output logic [WORD_CNT_W-1:0] word_cnt,
  output logic                  done,
  output logic                  err_illegal
);

  localparam logic [WORD_CNT_W:0] DEPTH_W = (WORD_CNT_W+1)'(DEPTH);

  state_e                state_q, state_d;
  logic                  im_we_q, im_we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           addr_q, addr_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic                  err_q, err_d;

  logic [31:0]           enc_word;
  logic                  enc_illegal;
  logic [WORD_CNT_W:0]   issued, issued_d;
  logic                  in_ready_w;
  logic                  accept;
  logic                  commit;

  instr_stream_writer_encode u_encode (
    .op      (bus.in_op),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .imm     (bus.in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // issued = committed words plus the one sitting in the output register
  assign issued     = {1'b0, word_cnt_q} + {{WORD_CNT_W{1'b0}}, im_we_q};
  assign commit     = im_we_q & bus.im_ready;
  assign in_ready_w = (state_q == ST_RUN) && (issued < DEPTH_W) && (!im_we_q || bus.im_ready);
  assign accept     = bus.in_valid & in_ready_w;

  always_comb begin
    im_we_d    = im_we_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    err_d      = accept & enc_illegal;

    if (commit && ({1'b0, word_cnt_q} < DEPTH_W)) begin
      word_cnt_d = word_cnt_q + 1'b1;
      addr_d     = addr_q + 32'd4;
    end

    // a legal accept reloads the register even on the commit cycle: no bubble
    if (accept && !enc_illegal) begin
      im_we_d = 1'b1;
      wdata_d = enc_word;
    end else if (commit) begin
      im_we_d = 1'b0;
    end

    issued_d = {1'b0, word_cnt_d} + {{WORD_CNT_W{1'b0}}, im_we_d};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (finish || (issued_d == DEPTH_W)) state_d = ST_DRAIN;
      ST_DRAIN: if (!im_we_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      im_we_q    <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      im_we_q    <= im_we_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.im_we    = im_we_q;
  assign bus.im_wdata = wdata_q;
  assign bus.im_addr  = addr_q;
  assign word_cnt     = word_cnt_q;
  assign done         = (state_q == ST_DONE);
  assign err_illegal  = err_q;

endmodule
